// File: rtl/mp_mul_seq.sv
// Word-serial schoolbook multiplier sequencer: T = A * B over NUM_WORDS-word operands,
// sharing one external MultiplyAdd unit. Optional cycle counter under MP_MUL_PERF_CNT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mp_mul_seq #(
    parameter int NUM_WORDS  = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
`ifdef MP_MUL_PERF_CNT_EN
    output logic [31:0]            perf_cycles,
`endif
    output logic [ADDR_WIDTH-1:0]  a_addr,
    input  logic [`DATA_WIDTH-1:0] a_rdata,
    output logic [ADDR_WIDTH-1:0]  b_addr,
    input  logic [`DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0]  t_addr,
    output logic                   t_we,
    output logic [`DATA_WIDTH-1:0] t_wdata,
    input  logic [`DATA_WIDTH-1:0] t_rdata,
    output logic [`DATA_WIDTH-1:0] mac_x,
    output logic [`DATA_WIDTH-1:0] mac_y,
    output logic [`DATA_WIDTH-1:0] mac_z,
    output logic [`DATA_WIDTH-1:0] mac_cin,
    input  logic [`DATA_WIDTH-1:0] mac_s,
    input  logic [`DATA_WIDTH-1:0] mac_cout
);

    localparam int DW = `DATA_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ROW   = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_MAC   = 3'd4;
    localparam logic [2:0] S_CARRY = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] WORD_LAST  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = ADDR_WIDTH'(2 * NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] NW         = ADDR_WIDTH'(NUM_WORDS);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] i_q, i_d;
    logic [ADDR_WIDTH-1:0] j_q, j_d;     // doubles as the clear address k in CLEAR
    logic [DW-1:0]         carry_q, carry_d;
    logic [DW-1:0]         b_reg_q, b_reg_d;

    logic [ADDR_WIDTH-1:0] ij_addr;
    assign ij_addr = i_q + j_q;

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        carry_d = carry_q;
        b_reg_d = b_reg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    j_d     = '0;
                end
            end
            S_CLEAR: begin
                if (j_q == CLEAR_LAST) begin
                    state_d = S_ROW;
                    i_d     = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_ROW: begin
                j_d     = '0;
                carry_d = '0;
                state_d = S_RD;
            end
            S_RD: begin
                // B word addressed in ROW is on b_rdata during the row's first RD
                if (j_q == '0) b_reg_d = b_rdata;
                state_d = S_MAC;
            end
            S_MAC: begin
                carry_d = mac_cout;
                if (j_q == WORD_LAST) begin
                    state_d = S_CARRY;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_CARRY: begin
                if (i_q == WORD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = S_ROW;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            carry_q <= '0;
            b_reg_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            carry_q <= carry_d;
            b_reg_q <= b_reg_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    // Decoded from state so an asynchronous reset forces every output to 0 at once.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        t_addr  = '0;
        t_we    = 1'b0;
        t_wdata = '0;
        mac_x   = '0;
        mac_y   = '0;
        mac_z   = '0;
        mac_cin = '0;
        case (state_q)
            S_CLEAR: begin
                busy   = 1'b1;
                t_addr = j_q;
                t_we   = 1'b1;
            end
            S_ROW: begin
                busy   = 1'b1;
                b_addr = i_q;
            end
            S_RD: begin
                busy   = 1'b1;
                a_addr = j_q;
                t_addr = ij_addr;
            end
            S_MAC: begin
                busy    = 1'b1;
                t_addr  = ij_addr;
                t_we    = 1'b1;
                t_wdata = mac_s;
                mac_x   = a_rdata;
                mac_y   = b_reg_q;
                mac_z   = t_rdata;
                mac_cin = carry_q;
            end
            S_CARRY: begin
                busy    = 1'b1;
                t_addr  = i_q + NW;
                t_we    = 1'b1;
                t_wdata = carry_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef MP_MUL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE && start) begin
            perf_d = '0;
        end else if (busy && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule
